// File: rtl/ttl_arbiter_8.sv
// ttl_arbiter_8: round-robin arbiter with a per-owner hold limit and registered one-hot grant
// Ports: clk; reset (sync, active-high); request[WIDTH_IN];
//        grant[WIDTH_IN] one-hot or zero; grant_index binary owner (0 when idle); valid = |grant.
// DELAY_RISE/DELAY_FALL are output timing annotations for back-annotated models;
// the synthesised outputs switch on the clock edge.
module ttl_arbiter_8 #(
  parameter int WIDTH_IN   = 8,
  parameter int HOLD_MAX   = 4,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH_IN-1:0] request,
  output logic [WIDTH_IN-1:0] grant,
  output logic [2:0]          grant_index,
  output logic                valid
);
  localparam int HW = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HMAX = HW'(HOLD_MAX);
  typedef enum logic {IDLE, OWNED} state_t;
  if (WIDTH_IN < 2 || WIDTH_IN > 8 || HOLD_MAX < 0 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_params
    $error("ttl_arbiter_8: illegal parameter value");
  end
  state_t        state;
  logic [2:0]    ptr, sel, k;
  logic [HW-1:0] hcnt;
  logic          keep;
  // Scan downward from PTR+W-1 to PTR so the lowest offset from PTR is the last write and wins.
  always_comb begin
    sel = '0;
    k = '0;
    for (int i = WIDTH_IN - 1; i >= 0; i--) begin
      k = 3'((int'(ptr) + i) % WIDTH_IN);
      if (request[k]) sel = k;
    end
  end
  // PTR already sits at owner+1, so an expired owner is naturally searched last.
  assign keep = state == OWNED && |(request & grant) && (HOLD_MAX == 0 || hcnt < HMAX);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      grant_index <= '0;
      valid <= 1'b0;
      ptr <= '0;
      hcnt <= '0;
    end else if (keep) begin
      if (!(&hcnt)) hcnt <= hcnt + 1'b1;
    end else if (|request) begin
      state <= OWNED;
      grant <= WIDTH_IN'(1) << sel;
      grant_index <= sel;
      valid <= 1'b1;
      ptr <= (sel == 3'(WIDTH_IN - 1)) ? 3'd0 : sel + 3'd1;
      hcnt <= HW'(1);
    end else begin
      state <= IDLE;
      grant <= '0;
      grant_index <= '0;
      valid <= 1'b0;
      hcnt <= '0;
    end
  end
endmodule

// File: doc/ttl_arbiter_8.md
TTL_ARBITER_8 -- requirements
Module: ttl_arbiter_8

Interface
REQ-001 Parameter WIDTH_IN, default 8: number of requesters; legal range 2..8.
REQ-002 Parameter HOLD_MAX, default 4: maximum consecutive grant cycles per owner; 0 = unlimited hold.
REQ-003 Parameter DELAY_RISE, default 0: rise delay applied to every output.
REQ-004 Parameter DELAY_FALL, default 0: fall delay applied to every output.
REQ-005 Clk  input  1  single clock; all state updates on the rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 Request  input  WIDTH_IN  request vector, bit i high = requester i wants the shared resource.
REQ-008 Grant  output  WIDTH_IN  registered one-hot grant vector; all-zero when no owner.
REQ-009 Grant_index  output  3  binary index of the current owner; 0 when no owner.
REQ-010 Valid  output  1  high whenever Grant is non-zero.

Function
REQ-011 Two-state FSM, SHALL be IDLE (no owner) and OWNED (one owner held in Grant).
REQ-012 Grant SHALL change only on a rising Clk edge; a Request change is reflected in Grant one cycle later, with no combinational path from Request to outputs.
REQ-013 Internal pointer PTR (0..WIDTH_IN-1) SHALL hold the search start; after each grant to index g, PTR = (g+1) mod WIDTH_IN.
REQ-014 Selection SHALL pick the first set Request bit scanning PTR, PTR+1, ... upward with wrap to 0, ending at PTR-1.
REQ-015 IDLE: Request all-zero -> stay IDLE, outputs zero; any bit set -> OWNED with the selected index granted at the next edge.
REQ-016 Hold counter HCNT SHALL load 1 on every new or renewed grant and increment each cycle the same owner is held, saturating at HOLD_MAX.
REQ-017 OWNED, Request[g]=1, and (HOLD_MAX=0 or HCNT<HOLD_MAX): keep grant g, PTR unchanged.
REQ-018 OWNED, Request[g]=0 (release): if other bits set, switch directly to the selected index at the next edge with no idle gap; else go IDLE.
REQ-019 OWNED, HCNT=HOLD_MAX with Request[g]=1 (expiry): select from PTR=g+1; g is searched last, so a sole requester g is re-granted with HCNT=1.
REQ-020 Grant SHALL be one-hot or zero in every cycle; Grant_index SHALL equal the set bit position and Valid = |Grant.
REQ-021 Request bits that rise and fall between edges SHALL be ignored; only values sampled at the edge count.
REQ-022 Simultaneous release by the owner and new requests: the new owner is chosen from the same-edge Request sample per REQ-014.
REQ-023 Outputs SHALL pass through DELAY_RISE/DELAY_FALL; internal state is undelayed.

Reset
REQ-024 Reset high at an edge SHALL force IDLE, Grant=0, Grant_index=0, Valid=0, PTR=0, HCNT=0, overriding any Request.
REQ-025 Reset asserted mid-ownership SHALL drop the grant at that edge; after release, the first search starts at index 0.
REQ-026 Outputs before the first Reset edge are undefined; the bench applies Reset for at least 1 cycle.

Verification (WIDTH_IN=8, HOLD_MAX=4)
REQ-027 Reset, then Request=8'b1000_0001 -> next edge Grant=8'b0000_0001, Grant_index=0, Valid=1.
REQ-028 Hold Request=8'b1000_0001 steady -> Grant=0x01 for 4 cycles, then 0x80 for 4 cycles, then 0x01 again, with no idle cycles.
REQ-029 Owner 0 drops while Request=8'b0001_0100 -> next edge Grant=8'b0000_0100, Grant_index=2.
REQ-030 Sole requester 5 held 10 cycles -> Grant=0x20 continuously; HCNT renews every 4 cycles, Valid never drops.
REQ-031 Reset asserted during ownership of index 6 with Request=0xC0 -> Grant=0 at that edge; after Reset low, Grant=0x40 (search from 0).
REQ-032 Request=0 after any grant -> next edge IDLE, Grant=0, Grant_index=0, Valid=0.
